// File: rtl/upc_checkout_monitor.sv
`default_nettype none
// ============================================================================
// Module      : upc_checkout_monitor
// Description : Tallies discounted/stolen checkout scans with saturating
//               counters and drives a timed blinking alarm whenever a stolen
//               item is scanned. Sits between the UPC status decoder and the
//               LED/HEX display logic on a single clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module upc_checkout_monitor #(
   parameter int BLINK_HALF = 25000000,  // cycles per LED on/off phase (>= 2)
   parameter int NUM_BLINKS = 3,         // full on/off periods per trigger (>= 1)
   parameter int CNT_W      = 4          // width of each tally counter
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             scan,
   input  logic             D,
   input  logic             S,
   input  logic             ack,
   input  logic             clr_counts,
   output logic             alarm,
   output logic             blink,
   output logic [CNT_W-1:0] disc_cnt,
   output logic [CNT_W-1:0] stolen_cnt
);

   localparam int TMR_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int BCNT_W = (NUM_BLINKS > 1) ? $clog2(NUM_BLINKS) : 1;

   localparam logic [TMR_W-1:0]  C_TMR_LAST  = TMR_W'(BLINK_HALF - 1);
   localparam logic [TMR_W-1:0]  C_TMR_ONE   = TMR_W'(1);
   localparam logic [BCNT_W-1:0] C_BCNT_LAST = BCNT_W'(NUM_BLINKS - 1);
   localparam logic [BCNT_W-1:0] C_BCNT_ONE  = BCNT_W'(1);
   localparam logic [CNT_W-1:0]  C_CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [TMR_W-1:0]   r_timer;
   logic [TMR_W-1:0]   w_timer_nxt;
   logic [BCNT_W-1:0]  r_bcnt;
   logic [BCNT_W-1:0]  w_bcnt_nxt;
   logic               r_alarm;
   logic               r_blink;
   logic [CNT_W-1:0]   r_disc_cnt;
   logic [CNT_W-1:0]   r_stolen_cnt;
   logic               w_trig;

   // A stolen item scanned at any point (re)starts the alarm sequence.
   assign w_trig = scan & S;

   // Alarm FSM state, phase timer and blink counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_bcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_bcnt  <= w_bcnt_nxt;
      end
   end

   // Next-state logic: retrigger beats ack and end-of-sequence; ack aborts.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_bcnt_nxt  = r_bcnt;
      case (r_state)
         ST_IDLE: begin
            if (w_trig) begin
               w_state_nxt = ST_ON;
               w_timer_nxt = '0;
               w_bcnt_nxt  = '0;
            end
         end
         ST_ON: begin
            if (w_trig) begin
               w_state_nxt = ST_ON;
               w_timer_nxt = '0;
               w_bcnt_nxt  = '0;
            end else if (ack) begin
               w_state_nxt = ST_IDLE;
               w_timer_nxt = '0;
               w_bcnt_nxt  = '0;
            end else if (r_timer == C_TMR_LAST) begin
               w_state_nxt = ST_OFF;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + C_TMR_ONE;
            end
         end
         ST_OFF: begin
            if (w_trig) begin
               w_state_nxt = ST_ON;
               w_timer_nxt = '0;
               w_bcnt_nxt  = '0;
            end else if (ack) begin
               w_state_nxt = ST_IDLE;
               w_timer_nxt = '0;
               w_bcnt_nxt  = '0;
            end else if (r_timer == C_TMR_LAST) begin
               w_timer_nxt = '0;
               if (r_bcnt == C_BCNT_LAST) begin
                  w_state_nxt = ST_IDLE;
                  w_bcnt_nxt  = '0;
               end else begin
                  w_state_nxt = ST_ON;
                  w_bcnt_nxt  = r_bcnt + C_BCNT_ONE;
               end
            end else begin
               w_timer_nxt = r_timer + C_TMR_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
            w_bcnt_nxt  = '0;
         end
      endcase
   end

   // Registered LED outputs decoded from the next state so they align with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alarm <= 1'b0;
         r_blink <= 1'b0;
      end else begin
         r_alarm <= (w_state_nxt != ST_IDLE);
         r_blink <= (w_state_nxt == ST_ON);
      end
   end

   // Saturating tallies; clear takes priority over a same-cycle scan.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_disc_cnt   <= '0;
         r_stolen_cnt <= '0;
      end else if (clr_counts) begin
         r_disc_cnt   <= '0;
         r_stolen_cnt <= '0;
      end else if (scan) begin
         if (D && (r_disc_cnt != C_CNT_MAX)) begin
            r_disc_cnt <= r_disc_cnt + C_CNT_ONE;
         end
         if (S && (r_stolen_cnt != C_CNT_MAX)) begin
            r_stolen_cnt <= r_stolen_cnt + C_CNT_ONE;
         end
      end
   end

   assign alarm      = r_alarm;
   assign blink      = r_blink;
   assign disc_cnt   = r_disc_cnt;
   assign stolen_cnt = r_stolen_cnt;

endmodule
`default_nettype wire

// File: tb/tb_upc_checkout_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_upc_checkout_monitor
// Description : Scoreboard bench for upc_checkout_monitor. A driver applies
//               directed and random stimulus on the falling edge and pushes the
//               reference model's expected outputs; a monitor pops and compares
//               after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upc_checkout_monitor;

   localparam int BH    = 4;
   localparam int NB    = 2;
   localparam int CW    = 4;
   localparam int ALEN  = 2 * NB * BH;
   localparam int CMAX  = (1 << CW) - 1;

   typedef struct {
      bit alarm;
      bit blink;
      int disc;
      int stolen;
   } exp_t;

   logic          clk;
   logic          reset;
   logic          scan;
   logic          D;
   logic          S;
   logic          ack;
   logic          clr_counts;
   logic          alarm;
   logic          blink;
   logic [CW-1:0] disc_cnt;
   logic [CW-1:0] stolen_cnt;

   exp_t exp_q[$];
   int   n_checks;
   int   n_fail;

   // Reference model: alarm is "cycles left" plus "cycles elapsed" since trigger.
   int   m_left;
   int   m_elapsed;
   int   m_disc;
   int   m_stolen;

   upc_checkout_monitor #(
      .BLINK_HALF (BH),
      .NUM_BLINKS (NB),
      .CNT_W      (CW)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .scan       (scan),
      .D          (D),
      .S          (S),
      .ack        (ack),
      .clr_counts (clr_counts),
      .alarm      (alarm),
      .blink      (blink),
      .disc_cnt   (disc_cnt),
      .stolen_cnt (stolen_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.alarm  = (m_left > 0);
      e.blink  = (m_left > 0) && (((m_elapsed / BH) % 2) == 0);
      e.disc   = m_disc;
      e.stolen = m_stolen;
      return e;
   endfunction

   // One clock of stimulus: drive on the falling edge, advance model, push expectation.
   task automatic drive(input bit sc, input bit d, input bit s, input bit ak, input bit cl);
      @(negedge clk);
      reset      = 1'b0;
      scan       = sc;
      D          = d;
      S          = s;
      ack        = ak;
      clr_counts = cl;
      if (cl) begin
         m_disc   = 0;
         m_stolen = 0;
      end else if (sc) begin
         if (d) m_disc   = (m_disc   < CMAX) ? m_disc + 1   : CMAX;
         if (s) m_stolen = (m_stolen < CMAX) ? m_stolen + 1 : CMAX;
      end
      if (sc && s) begin
         m_left    = ALEN;
         m_elapsed = 0;
      end else if (ak) begin
         m_left    = 0;
         m_elapsed = 0;
      end else if (m_left > 0) begin
         m_left--;
         m_elapsed++;
      end
      exp_q.push_back(model_out());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Asynchronous reset pulse, asserted between edges and checked immediately.
   task automatic do_reset();
      @(negedge clk);
      #2;
      reset      = 1'b1;
      scan       = 1'b0;
      D          = 1'b0;
      S          = 1'b0;
      ack        = 1'b0;
      clr_counts = 1'b0;
      #1;
      chk("async_rst_alarm",  int'(alarm),      0);
      chk("async_rst_blink",  int'(blink),      0);
      chk("async_rst_disc",   int'(disc_cnt),   0);
      chk("async_rst_stolen", int'(stolen_cnt), 0);
      m_left    = 0;
      m_elapsed = 0;
      m_disc    = 0;
      m_stolen  = 0;
      @(negedge clk);
      exp_q.push_back(model_out());
   endtask

   // Monitor: after each rising edge compare DUT outputs to the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("alarm",      int'(alarm),      int'(e.alarm));
            chk("blink",      int'(blink),      int'(e.blink));
            chk("disc_cnt",   int'(disc_cnt),   e.disc);
            chk("stolen_cnt", int'(stolen_cnt), e.stolen);
         end
      end
   end

   initial begin
      int wait_cycles;
      n_checks   = 0;
      n_fail     = 0;
      m_left     = 0;
      m_elapsed  = 0;
      m_disc     = 0;
      m_stolen   = 0;
      reset      = 1'b1;
      scan       = 1'b0;
      D          = 1'b0;
      S          = 1'b0;
      ack        = 1'b0;
      clr_counts = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state and scan with no flags.
      idle(2);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);

      // Full untouched alarm sequence.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(ALEN + 3);

      // Reset asserted in the middle of an alarm.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(5);
      do_reset();
      idle(2);

      // Discount tally saturation, then clear beats a same-cycle scan.
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(2);

      // Both flags on one scan.
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(ALEN + 2);

      // Retrigger during the OFF phase.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(BH + 1);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(ALEN + 2);

      // Ack during ON, then ack coinciding with a stolen scan, then ack in IDLE.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(BH + 2);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(ALEN + 1);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Scan with S exactly on the last alarm cycle.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(ALEN - 1);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(ALEN + 1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            drive(($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 79) == 0));
         end
      end

      // Drain the scoreboard with a bounded wait.
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
